opti_out_sink: RTL and testbench
================================

Name: opti_out_sink

Overview:
- Output-side receiver for the IIR filter's sample strobe interface.
- Accepts one-cycle `data_out`/`valid_out` strobes from `opti_top`, which has no backpressure.
- Buffers samples in a FIFO and presents them to a downstream consumer over a ready/valid handshake.
- Monitors strobe spacing, overflow and sample counts so pacing faults (for example, nominal 1-in-10 cadence violated) are visible in hardware and in simulation.

Parameters:
- DW, 24, sample width (signed two's complement, passed through unaltered).
- DEPTH, 16, FIFO depth in samples; power of two, minimum 2.
- MIN_GAP, 10, minimum legal distance in cycles between consecutive input strobes.
- CW, 32, width of the sample and drop counters.

Ports:
- clk  in  1  single clock, all logic on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- s_data  in  DW  filter output sample; sampled only when s_valid=1.
- s_valid  in  1  one-cycle strobe from the filter; no ready is returned.
- m_data  out  DW  head-of-FIFO sample (first-word-fall-through).
- m_valid  out  1  high while the FIFO is non-empty.
- m_ready  in  1  consumer accept; a pop occurs when m_valid && m_ready.
- level  out  $clog2(DEPTH)+1  current FIFO occupancy.
- sample_cnt  out  CW  count of accepted samples.
- drop_cnt  out  CW  count of samples dropped on full.
- overflow  out  1  sticky: at least one drop since the last clear.
- gap_err  out  1  sticky: spacing violation since the last clear.
- last_gap  out  16  distance in cycles between the two most recent strobes.
- clr_flags  in  1  synchronous clear of overflow, gap_err, sample_cnt and drop_cnt.

Behaviour:
- Reset (async assert, any time including mid-transfer):
  - FIFO is emptied: pointers 0, level=0, m_valid=0, m_data=0.
  - sample_cnt=0, drop_cnt=0, overflow=0, gap_err=0, last_gap=0.
  - The gap monitor's "seen first strobe" flag is cleared.
  - No stale data may appear after reset deasserts.
- Push: on a cycle with s_valid=1, accept when level<DEPTH, or when level==DEPTH and a pop occurs in the same cycle.
  - Accept writes s_data at the write pointer and increments sample_cnt, wrapping modulo 2^CW.
- Drop: if s_valid=1, level==DEPTH and there is no pop, the sample is discarded.
  - drop_cnt increments (wrapping) and overflow is set.
  - FIFO contents and level are unchanged.
- Pop: m_valid && m_ready advances the read pointer.
  - Pointers wrap modulo DEPTH using an extra MSB for the full/empty distinction.
- Level update per cycle: +1 on push only, -1 on pop only, unchanged on both or neither.
- Latency: a strobe at cycle N into an empty FIFO gives m_valid=1 and m_data=sample at cycle N+1.
- Handshake: m_data is held stable while m_valid=1 and m_ready=0. Samples leave strictly in arrival order.
- Gap monitor:
  - A 16-bit counter gc loads 1 on each strobe and otherwise increments, saturating at 0xFFFF.
  - On a strobe with seen_first=1: last_gap<=gc; if gc<MIN_GAP, gap_err<=1.
  - The first strobe after reset sets seen_first and does not update last_gap or gap_err.
  - Example: strobes at cycles 10 and 20 give last_gap=10; strobes on back-to-back cycles give last_gap=1.
  - Dropped strobes are still monitored.
- clr_flags:
  - Clears overflow, gap_err, sample_cnt and drop_cnt on the next edge.
  - If a strobe, drop or error occurs in the same cycle, that event wins: the counter becomes 1 and the flag is set.
  - Does not touch FIFO contents, last_gap or seen_first.
- No arithmetic on data: the DW bits pass bit-exact, sign included.

Test Plan:
- Assert rst for 3 cycles mid-stream with level=5 and both flags set -> within the same cycle m_valid=0, level=0, all counters, flags and last_gap at 0. The first post-reset strobe does not update last_gap.
- Strobes every 10 cycles carrying 0x000001..0x000004, m_ready=1 -> m_valid pulses 1 cycle after each strobe with matching data; sample_cnt=4, last_gap=10, gap_err=0.
- m_ready=0, 18 strobes at gap 10 -> level=16, sample_cnt=16, drop_cnt=2, overflow=1. Then m_ready=1 -> 16 words out in order, level reaches 0 and m_valid=0.
- With FIFO full, strobe coincides with a pop -> sample accepted, level stays 16, overflow stays 0.
- Two strobes 5 cycles apart -> last_gap=5, gap_err=1. Pulse clr_flags -> gap_err=0, sample_cnt=0, last_gap stays 5.
- Samples 0x800000 and 0x7FFFFF -> m_data exactly 0x800000 then 0x7FFFFF.

Source files
------------

// File: rtl/opti_out_sink.sv
// rtl/opti_out_sink.sv - FWFT sample FIFO behind a no-backpressure strobe source, with pacing monitors
module opti_out_sink #(
    parameter int DW      = 24,
    parameter int DEPTH   = 16,
    parameter int MIN_GAP = 10,
    parameter int CW      = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [DW-1:0]            s_data,
    input  logic                     s_valid,
    output logic [DW-1:0]            m_data,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic [$clog2(DEPTH):0]   level,
    output logic [CW-1:0]            sample_cnt,
    output logic [CW-1:0]            drop_cnt,
    output logic                     overflow,
    output logic                     gap_err,
    output logic [15:0]              last_gap,
    input  logic                     clr_flags
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL = DEPTH[AW:0];

    logic [DW-1:0] mem [DEPTH];
    logic [AW:0]   wr_ptr, rd_ptr;
    logic [15:0]   gc;
    logic          seen_first;
    logic          full, pop, push, drop, gap_short;

    assign level     = wr_ptr - rd_ptr;
    assign m_valid   = (wr_ptr != rd_ptr);
    assign full      = (level == FULL_LVL);
    assign pop       = m_valid && m_ready;
    assign push      = s_valid && (!full || pop);
    assign drop      = s_valid && full && !pop;
    assign gap_short = (gc < 16'(MIN_GAP));

    // Gate the head word so nothing left in the array is visible while empty
    assign m_data = m_valid ? mem[rd_ptr[AW-1:0]] : '0;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= s_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Counters and sticky flags: a same-cycle event takes priority over the clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sample_cnt <= '0;
            drop_cnt   <= '0;
            overflow   <= 1'b0;
            gap_err    <= 1'b0;
        end else begin
            if (push)           sample_cnt <= (clr_flags ? '0 : sample_cnt) + 1'b1;
            else if (clr_flags) sample_cnt <= '0;

            if (drop)           drop_cnt <= (clr_flags ? '0 : drop_cnt) + 1'b1;
            else if (clr_flags) drop_cnt <= '0;

            if (drop)           overflow <= 1'b1;
            else if (clr_flags) overflow <= 1'b0;

            if (s_valid && seen_first && gap_short) gap_err <= 1'b1;
            else if (clr_flags)                     gap_err <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gc         <= '0;
            seen_first <= 1'b0;
            last_gap   <= '0;
        end else begin
            if (s_valid) begin
                gc         <= 16'd1;
                seen_first <= 1'b1;
                if (seen_first) last_gap <= gc;
            end else if (gc != 16'hFFFF) begin
                gc <= gc + 16'd1;
            end
        end
    end
endmodule

// File: tb/tb_opti_out_sink.sv
// tb/tb_opti_out_sink.sv - randomized and directed bench for opti_out_sink against a queue-based model
module tb_opti_out_sink;
    localparam int DW = 24, DEPTH = 16, MIN_GAP = 10, CW = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] s_data = '0;
    logic          s_valid = 1'b0;
    logic [DW-1:0] m_data;
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic [4:0]    level;
    logic [CW-1:0] sample_cnt, drop_cnt;
    logic          overflow, gap_err;
    logic [15:0]   last_gap;
    logic          clr_flags = 1'b0;

    opti_out_sink #(.DW(DW), .DEPTH(DEPTH), .MIN_GAP(MIN_GAP), .CW(CW)) dut (
        .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .level(level),
        .sample_cnt(sample_cnt), .drop_cnt(drop_cnt), .overflow(overflow),
        .gap_err(gap_err), .last_gap(last_gap), .clr_flags(clr_flags)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;

    logic [DW-1:0] q[$];
    logic [CW-1:0] e_sample, e_drop;
    logic          e_ovf, e_gerr, e_seen;
    logic [15:0]   e_last_gap;
    longint        cyc = 0, prev_cyc = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".m_valid"}, 64'(m_valid), 64'(q.size() != 0));
        chk({tag, ".m_data"}, 64'(m_data), (q.size() != 0) ? 64'(q[0]) : 64'd0);
        chk({tag, ".level"}, 64'(level), 64'(q.size()));
        chk({tag, ".sample_cnt"}, 64'(sample_cnt), 64'(e_sample));
        chk({tag, ".drop_cnt"}, 64'(drop_cnt), 64'(e_drop));
        chk({tag, ".overflow"}, 64'(overflow), 64'(e_ovf));
        chk({tag, ".gap_err"}, 64'(gap_err), 64'(e_gerr));
        chk({tag, ".last_gap"}, 64'(last_gap), 64'(e_last_gap));
    endtask

    task automatic model_reset();
        q.delete();
        e_sample = '0; e_drop = '0; e_ovf = 0; e_gerr = 0; e_seen = 0; e_last_gap = '0;
    endtask

    // One clock: drive inputs, advance the model from the rules, check after the edge
    task automatic cycle(input logic sv, input logic [DW-1:0] sd, input logic rdy, input logic clr);
        logic   was_full, do_pop;
        longint gap;
        s_valid = sv; s_data = sd; m_ready = rdy; clr_flags = clr;
        was_full = (q.size() == DEPTH);
        do_pop   = (q.size() != 0) && rdy;
        if (clr) begin
            e_sample = '0; e_drop = '0; e_ovf = 0; e_gerr = 0;
        end
        if (sv) begin
            if (e_seen) begin
                gap = cyc - prev_cyc;
                if (gap > 65535) gap = 65535;
                e_last_gap = 16'(gap);
                if (gap < MIN_GAP) e_gerr = 1;
            end
            e_seen = 1;
            prev_cyc = cyc;
        end
        if (do_pop) void'(q.pop_front());
        if (sv && (!was_full || do_pop)) begin
            q.push_back(sd);
            e_sample = e_sample + 1;
        end else if (sv) begin
            e_drop = e_drop + 1;
            e_ovf = 1;
        end
        @(posedge clk);
        #1;
        cyc++;
        s_valid = 0; clr_flags = 0;
        check_all("cyc");
    endtask

    task automatic do_reset();
        rst = 1;
        #1;
        model_reset();
        check_all("rst_async");
        repeat (3) @(posedge clk);
        #1;
        rst = 0;
        check_all("rst_release");
    endtask

    initial begin
        model_reset();
        #1;
        do_reset();

        // Strobes every 10 cycles with consumer always ready
        for (int i = 1; i <= 4; i++) begin
            cycle(1, DW'(i), 1, 0);
            repeat (9) cycle(0, '0, 1, 0);
        end
        chk("cadence.sample_cnt", 64'(sample_cnt), 64'd4);
        chk("cadence.last_gap", 64'(last_gap), 64'd10);
        chk("cadence.gap_err", 64'(gap_err), 64'd0);

        // Overfill with consumer stalled
        cycle(0, '0, 0, 1);
        for (int i = 0; i < 18; i++) begin
            cycle(1, DW'($urandom), 0, 0);
            repeat (9) cycle(0, '0, 0, 0);
        end
        chk("fill.level", 64'(level), 64'd16);
        chk("fill.sample_cnt", 64'(sample_cnt), 64'd16);
        chk("fill.drop_cnt", 64'(drop_cnt), 64'd2);
        chk("fill.overflow", 64'(overflow), 64'd1);

        // Full FIFO, strobe coincides with a pop
        cycle(0, '0, 0, 1);
        repeat (9) cycle(0, '0, 0, 0);
        cycle(1, 24'hABCDEF, 1, 0);
        chk("fullpop.level", 64'(level), 64'd16);
        chk("fullpop.overflow", 64'(overflow), 64'd0);

        for (int i = 0; i < 40 && q.size() != 0; i++) cycle(0, '0, 1, 0);
        chk("drain.m_valid", 64'(m_valid), 64'd0);
        chk("drain.level", 64'(level), 64'd0);

        // Short gap, then clear
        repeat (12) cycle(0, '0, 1, 0);
        cycle(1, DW'($urandom), 1, 0);
        repeat (4) cycle(0, '0, 1, 0);
        cycle(1, DW'($urandom), 1, 0);
        chk("short.last_gap", 64'(last_gap), 64'd5);
        chk("short.gap_err", 64'(gap_err), 64'd1);
        cycle(0, '0, 1, 1);
        chk("clr.gap_err", 64'(gap_err), 64'd0);
        chk("clr.sample_cnt", 64'(sample_cnt), 64'd0);
        chk("clr.last_gap", 64'(last_gap), 64'd5);

        // Sign extremes pass bit-exact
        repeat (10) cycle(0, '0, 0, 0);
        cycle(1, 24'h800000, 0, 0);
        repeat (9) cycle(0, '0, 0, 0);
        cycle(1, 24'h7FFFFF, 0, 0);
        chk("sign.head", 64'(m_data), 64'h800000);
        cycle(0, '0, 1, 0);
        chk("sign.next", 64'(m_data), 64'h7FFFFF);
        cycle(0, '0, 1, 0);

        // Randomized traffic
        for (int i = 0; i < 400; i++)
            cycle($urandom_range(0, 3) == 0, DW'($urandom), 1'($urandom_range(0, 1)),
                  $urandom_range(0, 31) == 0);

        // Build level=5 with both flags set, then reset mid-stream
        for (int i = 0; i < 40 && q.size() != 0; i++) cycle(0, '0, 1, 0);
        for (int i = 0; i < 17; i++) begin
            cycle(1, DW'($urandom), 0, 0);
            cycle(0, '0, 0, 0);
        end
        repeat (11) cycle(0, '0, 1, 0);
        chk("pre_rst.level", 64'(level), 64'd5);
        chk("pre_rst.overflow", 64'(overflow), 64'd1);
        chk("pre_rst.gap_err", 64'(gap_err), 64'd1);
        do_reset();
        cycle(1, 24'h123456, 0, 0);
        chk("post_rst.last_gap", 64'(last_gap), 64'd0);
        chk("post_rst.m_data", 64'(m_data), 64'h123456);
        repeat (2) cycle(0, '0, 0, 0);
        cycle(1, 24'h654321, 1, 0);
        chk("post_rst.gap3", 64'(last_gap), 64'd3);
        repeat (4) cycle(0, '0, 1, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
